// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap initiator: cause codes, ex_exc bit positions,
// FSM states and the latched trap record.
package trap_ctrl_pkg;

    // Cause codes as {interrupt, code[3:0]}
    localparam logic [4:0] CAUSE_INSTR_MIS = 5'h00;
    localparam logic [4:0] CAUSE_ILLEGAL   = 5'h02;
    localparam logic [4:0] CAUSE_EBREAK    = 5'h03;
    localparam logic [4:0] CAUSE_LOAD_MIS  = 5'h04;
    localparam logic [4:0] CAUSE_STORE_MIS = 5'h06;
    localparam logic [4:0] CAUSE_ECALL     = 5'h0B;
    localparam logic [4:0] CAUSE_IRQ_EXT   = 5'h1B;

    // Bit positions inside ex_exc
    localparam int EXC_INSTR_MIS = 0;
    localparam int EXC_ILLEGAL   = 1;
    localparam int EXC_EBREAK    = 2;
    localparam int EXC_ECALL     = 3;
    localparam int EXC_LOAD_MIS  = 4;
    localparam int EXC_STORE_MIS = 5;
    localparam int EXC_W         = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAISE = 3'd1,
        ST_CAUSE = 3'd2,
        ST_TVAL  = 3'd3,
        ST_JUMP  = 3'd4,
        ST_MRET  = 3'd5
    } trap_state_e;

    typedef struct packed {
        logic [4:0]  src;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_info_t;

endpackage

// File: rtl/trap_prio.sv
// Fixed-priority trap selector: picks the winning exception (or the qualified irq)
// and the matching tval.
module trap_prio
    import trap_ctrl_pkg::*;
(
    input  logic [EXC_W-1:0] exc,
    input  logic             irq_req,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic [31:0]      target,
    input  logic [31:0]      dmem_addr,
    output logic             req,
    output logic [4:0]       src,
    output logic [31:0]      tval
);

    // ecall sits above the misaligned data accesses; irq always loses to any exception
    always_comb begin
        req  = 1'b1;
        src  = '0;
        tval = '0;
        if (exc[EXC_INSTR_MIS]) begin
            src  = CAUSE_INSTR_MIS;
            tval = target;
        end else if (exc[EXC_ILLEGAL]) begin
            src  = CAUSE_ILLEGAL;
            tval = instr;
        end else if (exc[EXC_EBREAK]) begin
            src  = CAUSE_EBREAK;
            tval = pc;
        end else if (exc[EXC_ECALL]) begin
            src  = CAUSE_ECALL;
        end else if (exc[EXC_LOAD_MIS]) begin
            src  = CAUSE_LOAD_MIS;
            tval = dmem_addr;
        end else if (exc[EXC_STORE_MIS]) begin
            src  = CAUSE_STORE_MIS;
            tval = dmem_addr;
        end else if (irq_req) begin
            src  = CAUSE_IRQ_EXT;
        end else begin
            req  = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap initiator: latches the winning trap, pulses trap for one cycle, waits out the
// CSR capture, then flushes and redirects fetch to mtvec (or to mepc on mret).
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int          IRQ_ENABLE = 1,
    parameter logic [31:0] MTVEC_MASK = 32'hFFFFFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_dmem_addr,
    input  logic [5:0]  ex_exc,
    input  logic        ex_mret,
    input  logic        irq,
    input  logic        irq_en,
    input  logic [31:0] mtvec_rdata,
    input  logic [31:0] mepc_rdata,
    output logic        trap,
    output logic [4:0]  trap_src,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_tval,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall
);

    trap_state_e      state, state_nxt;
    trap_info_t       info;
    logic [EXC_W-1:0] exc_v;
    logic             irq_req;
    logic             req;
    logic [4:0]       req_src;
    logic [31:0]      req_tval;

    assign exc_v   = ex_exc & {EXC_W{ex_valid}};
    assign irq_req = (IRQ_ENABLE != 0) && irq && irq_en && ex_valid;

    trap_prio u_prio (
        .exc       (exc_v),
        .irq_req   (irq_req),
        .pc        (ex_pc),
        .instr     (ex_instr),
        .target    (ex_target),
        .dmem_addr (ex_dmem_addr),
        .req       (req),
        .src       (req_src),
        .tval      (req_tval)
    );

    // The trap record is only captured from IDLE; it then holds until the next trap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            info  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req)
                info <= '{src: req_src, pc: ex_pc, tval: req_tval};
        end
    end

    always_comb begin
        state_nxt      = state;
        trap           = 1'b0;
        stall          = 1'b0;
        pipe_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            ST_IDLE: begin
                if (req)
                    state_nxt = ST_RAISE;
                else if (ex_valid && ex_mret)
                    state_nxt = ST_MRET;
            end
            ST_RAISE: begin
                trap      = 1'b1;
                stall     = 1'b1;
                state_nxt = ST_CAUSE;
            end
            ST_CAUSE: begin
                stall     = 1'b1;
                state_nxt = ST_TVAL;
            end
            ST_TVAL: begin
                stall     = 1'b1;
                state_nxt = ST_JUMP;
            end
            ST_JUMP: begin
                stall          = 1'b1;
                pipe_flush     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_rdata & MTVEC_MASK;
                state_nxt      = ST_IDLE;
            end
            ST_MRET: begin
                stall          = 1'b1;
                pipe_flush     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mepc_rdata;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign trap_src  = info.src;
    assign trap_pc   = info.pc;
    assign trap_tval = info.tval;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed corner cases plus randomized
// transactions scored against a transaction-level model of the trap rules.
module tb_trap_ctrl;

    localparam logic [31:0] MASK = 32'hFFFFFFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0, ex_instr = '0, ex_target = '0, ex_dmem_addr = '0;
    logic [5:0]  ex_exc = '0;
    logic        ex_mret = 1'b0, irq = 1'b0, irq_en = 1'b0;
    logic [31:0] mtvec_rdata = '0, mepc_rdata = '0;

    logic        trap, pipe_flush, redirect_valid, stall;
    logic [4:0]  trap_src;
    logic [31:0] trap_pc, trap_tval, redirect_pc;

    logic        nq_trap, nq_flush, nq_rv, nq_stall;
    logic [4:0]  nq_src;
    logic [31:0] nq_pc, nq_tval, nq_rpc;
    logic        nirq_sel = 1'b0;
    logic        nq_valid;

    int vectors = 0;
    int miscompares = 0;

    // Model of the latched trap record
    logic [4:0]  exp_src = '0;
    logic [31:0] exp_pc = '0, exp_tval = '0;

    always #5 clk = ~clk;

    trap_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_target(ex_target), .ex_dmem_addr(ex_dmem_addr), .ex_exc(ex_exc), .ex_mret(ex_mret),
        .irq(irq), .irq_en(irq_en), .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
        .trap(trap), .trap_src(trap_src), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall)
    );

    // Second instance with the interrupt path removed; it only sees live
    // instructions while nirq_sel is set so it stays idle otherwise.
    assign nq_valid = ex_valid & nirq_sel;

    trap_ctrl #(.IRQ_ENABLE(0)) u_noirq (
        .clk(clk), .rst_n(rst_n), .ex_valid(nq_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_target(ex_target), .ex_dmem_addr(ex_dmem_addr), .ex_exc(ex_exc), .ex_mret(ex_mret),
        .irq(irq), .irq_en(irq_en), .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
        .trap(nq_trap), .trap_src(nq_src), .trap_pc(nq_pc), .trap_tval(nq_tval),
        .pipe_flush(nq_flush), .redirect_valid(nq_rv), .redirect_pc(nq_rpc), .stall(nq_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level reference: walk the cause table in priority order.
    function automatic void ref_trap(input logic v, input logic [5:0] exc, input logic irq_q,
                                     input logic [31:0] pc, input logic [31:0] instr,
                                     input logic [31:0] tgt, input logic [31:0] dm,
                                     output bit take, output logic [4:0] src,
                                     output logic [31:0] tval);
        int          prio[6]  = '{0, 1, 2, 3, 4, 5};
        logic [4:0]  code[6]  = '{5'd0, 5'd2, 5'd3, 5'd11, 5'd4, 5'd6};
        logic [31:0] tvals[6];
        tvals = '{tgt, instr, pc, 32'd0, dm, dm};
        take = 0; src = '0; tval = '0;
        if (v) begin
            foreach (prio[k]) begin
                if (!take && exc[prio[k]]) begin
                    take = 1; src = code[prio[k]]; tval = tvals[prio[k]];
                end
            end
            if (!take && irq_q) begin
                take = 1; src = 5'h1B; tval = '0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag, input logic t, input logic st,
                                 input logic fl, input logic [31:0] rpc);
        chk({tag, ".trap"}, 32'(trap), 32'(t));
        chk({tag, ".stall"}, 32'(stall), 32'(st));
        chk({tag, ".flush"}, 32'(pipe_flush), 32'(fl));
        chk({tag, ".redir_v"}, 32'(redirect_valid), 32'(fl));
        chk({tag, ".redir_pc"}, redirect_pc, rpc);
        chk({tag, ".src"}, 32'(trap_src), 32'(exp_src));
        chk({tag, ".pc"}, trap_pc, exp_pc);
        chk({tag, ".tval"}, trap_tval, exp_tval);
    endtask

    // Live-looking traffic while the controller is busy; it must be ignored.
    task automatic drive_junk();
        ex_valid = 1'b1; ex_exc = 6'($urandom); ex_mret = 1'($urandom);
        irq = 1'b1; irq_en = 1'b1;
        ex_pc = $urandom; ex_instr = $urandom; ex_target = $urandom; ex_dmem_addr = $urandom;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input string tag, input logic v, input logic [5:0] exc,
                           input logic mret, input logic iq, input logic ien,
                           input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] tgt, input logic [31:0] dm,
                           input logic [31:0] mtvec, input logic [31:0] mepc);
        bit          take;
        logic [4:0]  src;
        logic [31:0] tval;
        check_outputs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 32'd0);
        ex_valid = v; ex_exc = exc; ex_mret = mret; irq = iq; irq_en = ien;
        ex_pc = pc; ex_instr = instr; ex_target = tgt; ex_dmem_addr = dm;
        mtvec_rdata = mtvec; mepc_rdata = mepc;
        ref_trap(v, exc, iq & ien, pc, instr, tgt, dm, take, src, tval);
        @(negedge clk);
        if (nirq_sel) begin
            chk({tag, ".noirq_trap"}, 32'(nq_trap), 32'd0);
            chk({tag, ".noirq_stall"}, 32'(nq_stall), 32'd0);
            nirq_sel = 1'b0;
        end
        if (take) begin
            exp_src = src; exp_pc = pc; exp_tval = tval;
            for (int s = 1; s <= 4; s++) begin
                if (s > 1) @(negedge clk);
                check_outputs($sformatf("%s.st%0d", tag, s), s == 1, 1'b1, s == 4,
                              (s == 4) ? (mtvec & MASK) : 32'd0);
                drive_junk();
            end
            @(negedge clk);
        end else if (v && mret) begin
            check_outputs({tag, ".mret"}, 1'b0, 1'b1, 1'b1, mepc);
            drive_junk();
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn("illegal", 1, 6'b000010, 0, 0, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h200, 32'h0);
        chk("illegal.src_lit", 32'(trap_src), 32'h02);
        run_txn("ld_st_irq", 1, 6'b110000, 0, 1, 1, 32'h80, 32'h13, 32'h0, 32'h1003, 32'h300, 32'h0);
        chk("ld_st_irq.src_lit", 32'(trap_src), 32'h04);
        nirq_sel = 1'b1;
        run_txn("irq", 1, 6'b000000, 0, 1, 1, 32'h40, 32'h13, 32'h0, 32'h0, 32'h400, 32'h0);
        chk("irq.src_lit", 32'(trap_src), 32'h1B);
        run_txn("irq_masked", 1, 6'b000000, 0, 1, 0, 32'h44, 32'h13, 32'h0, 32'h0, 32'h400, 32'h0);
        run_txn("mret", 1, 6'b000000, 1, 0, 0, 32'h50, 32'h30200073, 32'h0, 32'h0, 32'h400, 32'h104);
        run_txn("mret_ecall", 1, 6'b001000, 1, 0, 0, 32'h60, 32'h73, 32'h0, 32'h0, 32'h500, 32'h104);
        chk("mret_ecall.src_lit", 32'(trap_src), 32'h0B);
        run_txn("b2b_trap", 1, 6'b000100, 0, 0, 0, 32'h70, 32'h100073, 32'h0, 32'h0, 32'h600, 32'h104);
        run_txn("b2b_mret", 1, 6'b000000, 1, 0, 0, 32'h74, 32'h0, 32'h0, 32'h0, 32'h600, 32'h74);
        run_txn("mtvec_mode", 1, 6'b000001, 0, 0, 0, 32'h90, 32'h0, 32'h92, 32'h0, 32'h203, 32'h0);

        // Reset while the controller sits in CAUSE
        check_outputs("rst.idle", 1'b0, 1'b0, 1'b0, 32'd0);
        ex_valid = 1; ex_exc = 6'b000010; ex_pc = 32'h120; ex_instr = 32'hDEAD; mtvec_rdata = 32'h200;
        @(negedge clk);
        chk("rst.raise", 32'(trap), 32'd1);
        drive_junk();
        @(negedge clk);
        rst_n = 1'b0;
        ex_valid = 1'b0;
        #1;
        exp_src = '0; exp_pc = '0; exp_tval = '0;
        check_outputs("rst.mid", 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn("post_rst", 1, 6'b100000, 0, 0, 0, 32'h130, 32'h0, 32'h0, 32'h2002, 32'h240, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] e;
            e = ($urandom_range(0, 2) == 0) ? 6'd0 : (6'($urandom) & 6'($urandom) & 6'($urandom));
            run_txn($sformatf("rnd%0d", n), $urandom_range(0, 7) != 0, e,
                    $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                    $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
